// File: rtl/reorder_buf_pkg.sv
// ----------------------------------------------------------------------------
// reorder_buf_pkg
//  Shared sizing constants, types and helpers for the reorder buffer.
//  ROB ids run 1..ROB_SZ (id = index + 1); id 0 (ROB_ID_NONE) means "no tag".
//  No ports (package).
// ----------------------------------------------------------------------------
package reorder_buf_pkg;

  localparam int ROB_SZ = 16;
  localparam int ROB_AW = 4;
  localparam int CNT_W  = ROB_AW + 1;
  localparam int XLEN   = 32;
  localparam int RD_W   = 5;

  localparam logic [XLEN-1:0] ROB_ID_NONE = '0;
  localparam logic [CNT_W-1:0] ROB_CNT_FULL = CNT_W'(ROB_SZ);

  typedef logic [ROB_AW-1:0] rob_idx_t;

  // Per-entry fields fixed at allocation time.
  typedef struct packed {
    logic [RD_W-1:0] rd;
    logic            is_br;
    logic            is_st;
    logic            pred;
  } rob_meta_t;

  function automatic logic [XLEN-1:0] idx_to_id(input rob_idx_t idx);
    return XLEN'(idx) + XLEN'(1);
  endfunction

endpackage

// File: rtl/reorder_buf_rob_id_dec.sv
// ----------------------------------------------------------------------------
// rob_id_dec
//  Converts a 32-bit ROB id into a storage index and flags whether the id
//  names a real entry (1..ROB_SZ). Used for both lookups and both CDBs.
//  Ports:
//    i_id    in   XLEN    ROB id (0 = no tag)
//    o_idx   out  ROB_AW  entry index (id - 1, modulo ROB_SZ)
//    o_valid out  1       id is in 1..ROB_SZ
// ----------------------------------------------------------------------------
module rob_id_dec
  import reorder_buf_pkg::*;
(
  input  logic [XLEN-1:0] i_id,
  output rob_idx_t        o_idx,
  output logic            o_valid
);

  assign o_valid = (i_id != ROB_ID_NONE) && (i_id <= XLEN'(ROB_SZ));
  // Only the low bits matter for the index; out-of-range ids are masked by o_valid.
  assign o_idx   = i_id[ROB_AW-1:0] - ROB_AW'(1);

endmodule

// File: rtl/reorder_buf.sv
// ----------------------------------------------------------------------------
// reorder_buf
//  Circular in-order reorder buffer: allocates ids at issue, captures results
//  from the ex/ld CDBs, answers two operand lookups, retires one entry per
//  cycle in order and raises a flush pulse on a mispredicted branch.
//  Optional feature macro: ROB_PERF_CNT_EN (adds commit/flush counters).
//  Ports:
//    clk, rst, rdy                      clock, sync active-high reset, global enable
//    ID_alloc_flag/_rd/_is_br/_is_st/_pred   allocation request and entry fields
//    rob_alloc_id, rob_full             id for next allocation, buffer full
//    rob_id1/2 -> rob_id1/2_rdy/_val    combinational operand lookups
//    ex_cdb_flag/_rob_id/_val/_jump/_target   ALU result broadcast
//    ld_cdb_flag/_rob_id/_val           load result broadcast
//    ROB_cmt_flag/_rd/_rob_id/_val/_is_st     registered commit pulse and fields
//    jump_wrong_stall, jump_wrong_pc    registered mispredict flush pulse + redirect
//    perf_cmt_cnt, perf_flush_cnt       (ROB_PERF_CNT_EN only) event counters
// ----------------------------------------------------------------------------
module reorder_buf
  import reorder_buf_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            rdy,
  input  logic            ID_alloc_flag,
  input  logic [RD_W-1:0] ID_alloc_rd,
  input  logic            ID_alloc_is_br,
  input  logic            ID_alloc_is_st,
  input  logic            ID_alloc_pred,
  output logic [XLEN-1:0] rob_alloc_id,
  output logic            rob_full,
  input  logic [XLEN-1:0] rob_id1,
  input  logic [XLEN-1:0] rob_id2,
  output logic            rob_id1_rdy,
  output logic            rob_id2_rdy,
  output logic [XLEN-1:0] rob_id1_val,
  output logic [XLEN-1:0] rob_id2_val,
  input  logic            ex_cdb_flag,
  input  logic [XLEN-1:0] ex_cdb_rob_id,
  input  logic [XLEN-1:0] ex_cdb_val,
  input  logic            ex_cdb_jump,
  input  logic [XLEN-1:0] ex_cdb_target,
  input  logic            ld_cdb_flag,
  input  logic [XLEN-1:0] ld_cdb_rob_id,
  input  logic [XLEN-1:0] ld_cdb_val,
  output logic            ROB_cmt_flag,
  output logic [RD_W-1:0] ROB_cmt_rd,
  output logic [XLEN-1:0] ROB_cmt_rob_id,
  output logic [XLEN-1:0] ROB_cmt_val,
  output logic            ROB_cmt_is_st,
  output logic            jump_wrong_stall,
  output logic [XLEN-1:0] jump_wrong_pc
`ifdef ROB_PERF_CNT_EN
  ,
  output logic [31:0]     perf_cmt_cnt,
  output logic [31:0]     perf_flush_cnt
`endif
);

  // Entry storage, one array per field.
  logic [ROB_SZ-1:0] r_valid;
  logic [ROB_SZ-1:0] r_ready;
  logic [ROB_SZ-1:0] r_jump;
  rob_meta_t         r_meta   [ROB_SZ];
  logic [XLEN-1:0]   r_val    [ROB_SZ];
  logic [XLEN-1:0]   r_target [ROB_SZ];

  rob_idx_t          r_head;
  rob_idx_t          r_tail;
  logic [CNT_W-1:0]  r_count;

  logic              r_cmt_flag;
  logic [RD_W-1:0]   r_cmt_rd;
  logic [XLEN-1:0]   r_cmt_rob_id;
  logic [XLEN-1:0]   r_cmt_val;
  logic              r_cmt_is_st;
  logic              r_jump_wrong_stall;
  logic [XLEN-1:0]   r_jump_wrong_pc;

  rob_idx_t  w_l1_idx, w_l2_idx, w_ex_idx, w_ld_idx;
  logic      w_l1_ok, w_l2_ok, w_ex_ok, w_ld_ok;
  rob_meta_t w_head_meta;
  logic      w_full, w_commit, w_flush, w_alloc, w_ex_wr, w_ld_wr;

  rob_id_dec u_dec_l1 (.i_id(rob_id1),       .o_idx(w_l1_idx), .o_valid(w_l1_ok));
  rob_id_dec u_dec_l2 (.i_id(rob_id2),       .o_idx(w_l2_idx), .o_valid(w_l2_ok));
  rob_id_dec u_dec_ex (.i_id(ex_cdb_rob_id), .o_idx(w_ex_idx), .o_valid(w_ex_ok));
  rob_id_dec u_dec_ld (.i_id(ld_cdb_rob_id), .o_idx(w_ld_idx), .o_valid(w_ld_ok));

  assign w_head_meta = r_meta[r_head];
  assign w_full      = (r_count == ROB_CNT_FULL);
  assign w_commit    = rdy && r_valid[r_head] && r_ready[r_head];
  assign w_flush     = w_commit && w_head_meta.is_br && (r_jump[r_head] != w_head_meta.pred);
  // Full status uses the pre-edge count, so a slot freed by this cycle's commit is not reused yet.
  assign w_alloc     = rdy && ID_alloc_flag && !w_full && !w_flush;
  // Results for stale or unallocated ids are dropped; a flush discards everything in flight.
  assign w_ex_wr     = rdy && ex_cdb_flag && w_ex_ok && r_valid[w_ex_idx] && !w_flush;
  assign w_ld_wr     = rdy && ld_cdb_flag && w_ld_ok && r_valid[w_ld_idx] && !w_flush;

  // Control state: pointers, count, valid/ready bits and registered outputs.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid            <= '0;
      r_ready            <= '0;
      r_head             <= '0;
      r_tail             <= '0;
      r_count            <= '0;
      r_cmt_flag         <= 1'b0;
      r_cmt_rd           <= '0;
      r_cmt_rob_id       <= '0;
      r_cmt_val          <= '0;
      r_cmt_is_st        <= 1'b0;
      r_jump_wrong_stall <= 1'b0;
      r_jump_wrong_pc    <= '0;
    end else if (!rdy) begin
      r_cmt_flag         <= 1'b0;
      r_jump_wrong_stall <= 1'b0;
    end else begin
      r_cmt_flag         <= w_commit;
      r_jump_wrong_stall <= w_flush;
      if (w_commit) begin
        r_cmt_rd     <= w_head_meta.rd;
        r_cmt_rob_id <= idx_to_id(r_head);
        r_cmt_val    <= r_val[r_head];
        r_cmt_is_st  <= w_head_meta.is_st;
      end
      if (w_flush) begin
        r_jump_wrong_pc <= r_target[r_head];
        r_valid         <= '0;
        r_head          <= '0;
        r_tail          <= '0;
        r_count         <= '0;
      end else begin
        if (w_commit) begin
          r_valid[r_head] <= 1'b0;
          r_head          <= r_head + ROB_AW'(1);
        end
        if (w_alloc) begin
          r_valid[r_tail] <= 1'b1;
          r_ready[r_tail] <= 1'b0;
          r_tail          <= r_tail + ROB_AW'(1);
        end
        if (w_ld_wr) r_ready[w_ld_idx] <= 1'b1;
        if (w_ex_wr) r_ready[w_ex_idx] <= 1'b1;
        unique case ({w_alloc, w_commit})
          2'b10:   r_count <= r_count + CNT_W'(1);
          2'b01:   r_count <= r_count - CNT_W'(1);
          default: r_count <= r_count;
        endcase
      end
    end
  end

  // Payload storage.
  // NOTE: payload arrays carry no reset; an entry is only read once its valid/ready bits say it was written.
  always_ff @(posedge clk) begin
    if (w_alloc) begin
      r_meta[r_tail] <= '{rd: ID_alloc_rd, is_br: ID_alloc_is_br,
                          is_st: ID_alloc_is_st, pred: ID_alloc_pred};
      r_jump[r_tail] <= 1'b0;
    end
    if (w_ld_wr) r_val[w_ld_idx] <= ld_cdb_val;
    // ex is written after ld so it wins when both target the same entry.
    if (w_ex_wr) begin
      r_val[w_ex_idx] <= ex_cdb_val;
      if (r_meta[w_ex_idx].is_br) begin
        r_jump[w_ex_idx]   <= ex_cdb_jump;
        r_target[w_ex_idx] <= ex_cdb_target;
      end
    end
  end

  // Lookups see only settled entries; same-cycle CDB bypass lives in the register file.
  assign rob_id1_rdy = w_l1_ok && r_valid[w_l1_idx] && r_ready[w_l1_idx];
  assign rob_id2_rdy = w_l2_ok && r_valid[w_l2_idx] && r_ready[w_l2_idx];
  assign rob_id1_val = rob_id1_rdy ? r_val[w_l1_idx] : '0;
  assign rob_id2_val = rob_id2_rdy ? r_val[w_l2_idx] : '0;

  assign rob_alloc_id     = idx_to_id(r_tail);
  assign rob_full         = w_full;
  assign ROB_cmt_flag     = r_cmt_flag;
  assign ROB_cmt_rd       = r_cmt_rd;
  assign ROB_cmt_rob_id   = r_cmt_rob_id;
  assign ROB_cmt_val      = r_cmt_val;
  assign ROB_cmt_is_st    = r_cmt_is_st;
  assign jump_wrong_stall = r_jump_wrong_stall;
  assign jump_wrong_pc    = r_jump_wrong_pc;

`ifdef ROB_PERF_CNT_EN
  logic [31:0] r_perf_cmt_cnt;
  logic [31:0] r_perf_flush_cnt;

  // Free-running event counters; they wrap and are cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_cmt_cnt   <= '0;
      r_perf_flush_cnt <= '0;
    end else begin
      if (w_commit) r_perf_cmt_cnt   <= r_perf_cmt_cnt + 32'd1;
      if (w_flush)  r_perf_flush_cnt <= r_perf_flush_cnt + 32'd1;
    end
  end

  assign perf_cmt_cnt   = r_perf_cmt_cnt;
  assign perf_flush_cnt = r_perf_flush_cnt;
`endif

endmodule
